// File: rtl/oddr_gearbox_tx.sv
// Transmit-side DDR x1 gearbox.
// Takes parallel words over a valid/ready handshake and emits one 2-bit pair
// per SCLK cycle (DA = earlier/rising half, DB = later/falling half) toward an
// output DDR primitive. On request it emits a link-training pattern so the far
// end can find its pair boundary.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | outputs at IDLE_LEVEL, word boundary, ready for a word or training
// SHIFT | current output is data pair pair_cnt of the loaded word
// TRAIN | current output is training pair train_cnt (DA=1, DB=0)
module oddr_gearbox_tx #(
   parameter int   DATA_W       = 8,
   parameter int   TRAIN_CYCLES = 16,
   parameter logic IDLE_LEVEL   = 1'b0
) (
   input  logic              SCLK,
   input  logic              RSTN,
   input  logic [DATA_W-1:0] DIN,
   input  logic              DIN_VALID,
   output logic              DIN_READY,
   input  logic              TRAIN,
   output logic              DA,
   output logic              DB,
   output logic              FRAME,
   output logic              TRAIN_DONE,
   output logic              BUSY
);

   localparam int PAIRS = DATA_W / 2;
   localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam int TW    = $clog2(TRAIN_CYCLES + 1);

   localparam logic [PW-1:0] LAST_PAIR  = PW'(PAIRS - 1);
   localparam logic [TW-1:0] LAST_TRAIN = TW'(TRAIN_CYCLES - 1);

   // Reject unusable parameterisations at elaboration.
   generate
      if ((DATA_W < 2) || ((DATA_W % 2) != 0)) begin : g_bad_width
         $error("oddr_gearbox_tx: DATA_W must be even and >= 2");
      end
      if (TRAIN_CYCLES < 1) begin : g_bad_train
         $error("oddr_gearbox_tx: TRAIN_CYCLES must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      TRAIN_ST = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     pair_cnt, pair_nxt;
   logic [TW-1:0]     train_cnt, train_nxt;
   logic [DATA_W-1:0] sr, sr_nxt;
   logic              da_nxt, db_nxt, frame_nxt, done_nxt, busy_nxt;
   logic              boundary, last_pair, accept;

   // Word boundary: idle, or the final pair of a word is on the line.
   always_comb begin
      last_pair = (state == SHIFT) && (pair_cnt == LAST_PAIR);
      boundary  = (state == IDLE) || last_pair;
      // Gated by RSTN so ready stays low while reset is held.
      DIN_READY = RSTN && boundary && !TRAIN;
      accept    = DIN_VALID && DIN_READY;
   end

   // Next state and the registered values of every line output.
   always_comb begin
      state_nxt = state;
      pair_nxt  = pair_cnt;
      train_nxt = train_cnt;
      sr_nxt    = sr;
      da_nxt    = IDLE_LEVEL;
      db_nxt    = IDLE_LEVEL;
      frame_nxt = 1'b0;
      done_nxt  = 1'b0;
      busy_nxt  = 1'b0;

      case (state)
         IDLE, SHIFT: begin
            if ((state == SHIFT) && !last_pair) begin
               // Mid-word: present the next pair, words are never truncated.
               da_nxt    = sr[DATA_W-1];
               db_nxt    = sr[DATA_W-2];
               sr_nxt    = sr << 2;
               pair_nxt  = pair_cnt + PW'(1);
               busy_nxt  = 1'b1;
            end else if (accept) begin
               // First pair goes straight from DIN; the rest wait in sr.
               state_nxt = SHIFT;
               pair_nxt  = '0;
               da_nxt    = DIN[DATA_W-1];
               db_nxt    = DIN[DATA_W-2];
               sr_nxt    = DIN << 2;
               frame_nxt = 1'b1;
               busy_nxt  = 1'b1;
            end else if (TRAIN) begin
               state_nxt = TRAIN_ST;
               pair_nxt  = '0;
               train_nxt = '0;
               da_nxt    = 1'b1;
               db_nxt    = 1'b0;
               busy_nxt  = 1'b1;
            end else begin
               state_nxt = IDLE;
               pair_nxt  = '0;
            end
         end

         TRAIN_ST: begin
            if (train_cnt == LAST_TRAIN) begin
               done_nxt = 1'b1;
               if (TRAIN) begin
                  // Back-to-back burst: pattern continues without a gap.
                  train_nxt = '0;
                  da_nxt    = 1'b1;
                  db_nxt    = 1'b0;
                  busy_nxt  = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  train_nxt = '0;
               end
            end else begin
               train_nxt = train_cnt + TW'(1);
               da_nxt    = 1'b1;
               db_nxt    = 1'b0;
               busy_nxt  = 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
            pair_nxt  = '0;
            train_nxt = '0;
         end
      endcase
   end

   // State, counters, shift register and output registers.
   always_ff @(posedge SCLK or negedge RSTN) begin
      if (!RSTN) begin
         state      <= IDLE;
         pair_cnt   <= '0;
         train_cnt  <= '0;
         sr         <= '0;
         DA         <= IDLE_LEVEL;
         DB         <= IDLE_LEVEL;
         FRAME      <= 1'b0;
         TRAIN_DONE <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         state      <= state_nxt;
         pair_cnt   <= pair_nxt;
         train_cnt  <= train_nxt;
         sr         <= sr_nxt;
         DA         <= da_nxt;
         DB         <= db_nxt;
         FRAME      <= frame_nxt;
         TRAIN_DONE <= done_nxt;
         BUSY       <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_oddr_gearbox_tx.sv
// Bench for oddr_gearbox_tx: an 8-bit instance (IDLE_LEVEL=0, 16 training
// cycles) and a 2-bit instance (IDLE_LEVEL=1, 4 training cycles).
// Observed vector order: {DIN_READY, DA, DB, FRAME, BUSY, TRAIN_DONE}.
module tb_oddr_gearbox_tx;

   typedef logic [9:0] stim_t;   // {valid, train, din[7:0]}
   typedef logic [5:0] exp_t;

   logic       SCLK = 1'b0;
   logic       RSTN = 1'b0;

   logic [7:0] din1 = '0;
   logic       v1 = 1'b0, tr1 = 1'b0;
   logic       rdy1, da1, db1, fr1, dn1, bz1;

   logic [1:0] din2 = '0;
   logic       v2 = 1'b0, tr2 = 1'b0;
   logic       rdy2, da2, db2, fr2, dn2, bz2;

   logic [5:0] obs1, obs2;
   assign obs1 = {rdy1, da1, db1, fr1, bz1, dn1};
   assign obs2 = {rdy2, da2, db2, fr2, bz2, dn2};

   int checks = 0;
   int errors = 0;

   stim_t stim_q[$];
   exp_t  exp_q[$];

   oddr_gearbox_tx #(.DATA_W(8), .TRAIN_CYCLES(16), .IDLE_LEVEL(1'b0)) u_dut (
      .SCLK(SCLK), .RSTN(RSTN), .DIN(din1), .DIN_VALID(v1), .DIN_READY(rdy1),
      .TRAIN(tr1), .DA(da1), .DB(db1), .FRAME(fr1), .TRAIN_DONE(dn1), .BUSY(bz1));

   oddr_gearbox_tx #(.DATA_W(2), .TRAIN_CYCLES(4), .IDLE_LEVEL(1'b1)) u_dut2 (
      .SCLK(SCLK), .RSTN(RSTN), .DIN(din2), .DIN_VALID(v2), .DIN_READY(rdy2),
      .TRAIN(tr2), .DA(da2), .DB(db2), .FRAME(fr2), .TRAIN_DONE(dn2), .BUSY(bz2));

   always #5 SCLK = ~SCLK;

   function automatic exp_t ex(logic rdy, logic da, logic db, logic fr, logic bz, logic dn);
      return {rdy, da, db, fr, bz, dn};
   endfunction

   function automatic stim_t st(logic v, logic tr, logic [7:0] d);
      return {v, tr, d};
   endfunction

   task automatic push(input stim_t s, input exp_t e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   // Expected line pairs of an 8-bit word, MSB first; ready only on the last pair.
   task automatic push_word(input logic [7:0] w, input stim_t s, input logic rdy_last);
      for (int k = 0; k < 4; k++)
         push(s, ex((k == 3) ? rdy_last : 1'b0, w[7-2*k], w[6-2*k], k == 0, 1'b1, 1'b0));
   endtask

   task automatic apply1(input stim_t s);
      v1   = s[9];
      tr1  = s[8];
      din1 = s[7:0];
   endtask

   task automatic apply2(input stim_t s);
      v2   = s[9];
      tr2  = s[8];
      din2 = s[1:0];
   endtask

   task automatic test_reset();
      repeat (2) @(posedge SCLK);
      #1;
      checks++;
      if (obs1 !== 6'b000000) begin
         errors++;
         $display("FAIL reset_w8 obs=%b exp=%b", obs1, 6'b000000);
      end
      checks++;
      if (obs2 !== 6'b011000) begin
         errors++;
         $display("FAIL reset_w2 obs=%b exp=%b", obs2, 6'b011000);
      end
      RSTN = 1'b1;
   endtask

   task automatic test_single();
      stim_t s;
      exp_t  e;
      int    c = 0;
      push(st(1, 0, 8'hB4), ex(1, 0, 0, 0, 0, 0));
      push_word(8'hB4, st(0, 0, 8'h00), 1'b1);
      push(st(0, 0, 8'h00), ex(1, 0, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         apply1(s);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs1 !== e) begin
            errors++;
            $display("FAIL single cyc%0d obs=%b exp=%b", c, obs1, e);
         end
         c++;
         @(posedge SCLK);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      stim_t s;
      exp_t  e;
      int    c = 0;
      push(st(1, 0, 8'hFF), ex(1, 0, 0, 0, 0, 0));
      push_word(8'hFF, st(1, 0, 8'h00), 1'b1);
      push_word(8'h00, st(0, 0, 8'h00), 1'b1);
      push(st(0, 0, 8'h00), ex(1, 0, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         apply1(s);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs1 !== e) begin
            errors++;
            $display("FAIL back_to_back cyc%0d obs=%b exp=%b", c, obs1, e);
         end
         c++;
         @(posedge SCLK);
         #1;
      end
   endtask

   task automatic test_train_priority();
      stim_t s;
      exp_t  e;
      int    c = 0;
      push(st(1, 0, 8'hA5), ex(1, 0, 0, 0, 0, 0));
      push(st(0, 0, 8'h00), ex(0, 1, 0, 1, 1, 0));
      push(st(0, 1, 8'h00), ex(0, 1, 0, 0, 1, 0));
      push(st(1, 1, 8'h55), ex(0, 0, 1, 0, 1, 0));
      push(st(1, 1, 8'h55), ex(0, 0, 1, 0, 1, 0));
      for (int k = 0; k < 16; k++)
         push(st(k < 15, k < 5, 8'h55), ex(0, 1, 0, 0, 1, 0));
      push(st(0, 0, 8'h00), ex(1, 0, 0, 0, 0, 1));
      push(st(0, 0, 8'h00), ex(1, 0, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         apply1(s);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs1 !== e) begin
            errors++;
            $display("FAIL train_priority cyc%0d obs=%b exp=%b", c, obs1, e);
         end
         c++;
         @(posedge SCLK);
         #1;
      end
   endtask

   task automatic test_train_repeat();
      stim_t s;
      exp_t  e;
      int    c = 0;
      push(st(0, 1, 8'h00), ex(0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 16; k++)
         push(st(0, 1, 8'h00), ex(0, 1, 0, 0, 1, 0));
      for (int k = 0; k < 16; k++)
         push(st(0, 0, 8'h00), ex(0, 1, 0, 0, 1, k == 0));
      push(st(0, 0, 8'h00), ex(1, 0, 0, 0, 0, 1));
      push(st(0, 0, 8'h00), ex(1, 0, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         apply1(s);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs1 !== e) begin
            errors++;
            $display("FAIL train_repeat cyc%0d obs=%b exp=%b", c, obs1, e);
         end
         c++;
         @(posedge SCLK);
         #1;
      end
   endtask

   task automatic test_stall();
      stim_t s;
      exp_t  e;
      int    c = 0;
      push(st(0, 0, 8'h12), ex(1, 0, 0, 0, 0, 0));
      push(st(0, 0, 8'hEF), ex(1, 0, 0, 0, 0, 0));
      push(st(0, 0, 8'h99), ex(1, 0, 0, 0, 0, 0));
      push(st(0, 0, 8'h00), ex(1, 0, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         apply1(s);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs1 !== e) begin
            errors++;
            $display("FAIL stall cyc%0d obs=%b exp=%b", c, obs1, e);
         end
         c++;
         @(posedge SCLK);
         #1;
      end
   endtask

   task automatic test_async_reset();
      stim_t s;
      exp_t  e;
      int    c = 0;
      // C3 accepted, first two pairs seen, then reset lands mid-cycle.
      push(st(1, 0, 8'hC3), ex(1, 0, 0, 0, 0, 0));
      push(st(0, 0, 8'h00), ex(0, 1, 1, 1, 1, 0));
      push(st(0, 0, 8'h00), ex(0, 0, 0, 0, 1, 0));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         apply1(s);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs1 !== e) begin
            errors++;
            $display("FAIL async_pre cyc%0d obs=%b exp=%b", c, obs1, e);
         end
         c++;
         if (exp_q.size() > 0) begin
            @(posedge SCLK);
            #1;
         end
      end
      RSTN = 1'b0;
      #1;
      checks++;
      if (obs1 !== 6'b000000) begin
         errors++;
         $display("FAIL async_mid_w8 obs=%b exp=%b", obs1, 6'b000000);
      end
      checks++;
      if (obs2 !== 6'b011000) begin
         errors++;
         $display("FAIL async_mid_w2 obs=%b exp=%b", obs2, 6'b011000);
      end
      @(posedge SCLK);
      #1;
      checks++;
      if (obs1 !== 6'b000000) begin
         errors++;
         $display("FAIL async_held obs=%b exp=%b", obs1, 6'b000000);
      end
      RSTN = 1'b1;
      c = 0;
      push(st(1, 0, 8'h3C), ex(1, 0, 0, 0, 0, 0));
      push_word(8'h3C, st(0, 0, 8'h00), 1'b1);
      push(st(0, 0, 8'h00), ex(1, 0, 0, 0, 0, 0));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         apply1(s);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs1 !== e) begin
            errors++;
            $display("FAIL async_post cyc%0d obs=%b exp=%b", c, obs1, e);
         end
         c++;
         @(posedge SCLK);
         #1;
      end
   endtask

   task automatic test_width2();
      stim_t s;
      exp_t  e;
      int    c = 0;
      push(st(1, 0, 8'h02), ex(1, 1, 1, 0, 0, 0));
      push(st(1, 0, 8'h01), ex(1, 1, 0, 1, 1, 0));
      push(st(1, 0, 8'h03), ex(1, 0, 1, 1, 1, 0));
      push(st(0, 0, 8'h00), ex(1, 1, 1, 1, 1, 0));
      push(st(0, 0, 8'h00), ex(1, 1, 1, 0, 0, 0));
      push(st(1, 1, 8'h02), ex(0, 1, 1, 0, 0, 0));
      for (int k = 0; k < 4; k++)
         push(st(0, 0, 8'h00), ex(0, 1, 0, 0, 1, 0));
      push(st(0, 0, 8'h00), ex(1, 1, 1, 0, 0, 1));
      push(st(0, 0, 8'h00), ex(1, 1, 1, 0, 0, 0));
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         apply2(s);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs2 !== e) begin
            errors++;
            $display("FAIL width2 cyc%0d obs=%b exp=%b", c, obs2, e);
         end
         c++;
         @(posedge SCLK);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_train_priority();
      test_train_repeat();
      test_stall();
      test_async_reset();
      test_width2();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
